// File: rtl/if_id_pipe_if.sv
// if_id_pipe_if: fetch/decode handshake bundle for the IF/ID pipeline register.
interface if_id_pipe_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_pc4;
    logic              if_ready;
    logic              id_valid;
    logic [DATA_W-1:0] id_instr;
    logic [DATA_W-1:0] id_pc4;
    logic              id_ready;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output if_valid, if_instr, if_pc4, id_ready, flush,
        input  if_ready, id_valid, id_instr, id_pc4, stall_cnt, flush_cnt
    );

    modport slave (
        input  if_valid, if_instr, if_pc4, id_ready, flush,
        output if_ready, id_valid, id_instr, id_pc4, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_pipe.sv
// if_id_pipe: two-entry skid-buffered IF/ID register with flush and saturating stall/flush counters.
module if_id_pipe #(
    parameter int               DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0,
    parameter int               CNT_W     = 16
) (
    input logic         clk,
    input logic         reset,
    if_id_pipe_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state, state_n;
    logic              rdy, valid;
    logic [DATA_W-1:0] main_instr, main_pc4, skid_instr, skid_pc4;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              in_fire, out_fire;

    assign in_fire  = bus.if_valid & rdy;
    assign out_fire = valid & bus.id_ready;

    always_comb begin
        state_n = bus.flush ? EMPTY :
                  state == EMPTY ? (in_fire ? ONE : EMPTY) :
                  state == ONE ? (in_fire ? (out_fire ? ONE : TWO) : (out_fire ? EMPTY : ONE)) :
                  (out_fire ? ONE : TWO);
    end

    // The main slot doubles as the output register; it is parked at NOP whenever empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            rdy        <= 1'b1;
            valid      <= 1'b0;
            main_instr <= NOP_INSTR;
            main_pc4   <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state <= state_n;
            rdy   <= state_n != TWO;
            valid <= state_n != EMPTY;
            if (state_n == EMPTY) begin
                main_instr <= NOP_INSTR;
                main_pc4   <= '0;
            end else if (state == TWO && out_fire) begin
                main_instr <= skid_instr;
                main_pc4   <= skid_pc4;
            end else if (in_fire && (state == EMPTY || out_fire)) begin
                main_instr <= bus.if_instr;
                main_pc4   <= bus.if_pc4;
            end
            if (in_fire && state == ONE && !out_fire) begin
                skid_instr <= bus.if_instr;
                skid_pc4   <= bus.if_pc4;
            end
            if (valid && !bus.id_ready && !bus.flush && !(&stall_q))
                stall_q <= stall_q + CNT_W'(1);
            if (bus.flush && (state != EMPTY || in_fire) && !(&flush_q))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.if_ready  = rdy;
    assign bus.id_valid  = valid;
    assign bus.id_instr  = main_instr;
    assign bus.id_pc4    = main_pc4;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule
